// File: rtl/alu_pkg.sv
// Shared encodings for the decode stage: ALU function codes, B-operand selects,
// MIPS opcode/funct constants and the registered control bundle layout.
// No logic; imported by the interface-side top and the decode lookup.
package alu_pkg;

   // ALU function codes driven on oALUFun
   localparam logic [5:0] ALU_ADD = 6'b000000;
   localparam logic [5:0] ALU_SUB = 6'b000001;
   localparam logic [5:0] ALU_AND = 6'b011000;
   localparam logic [5:0] ALU_OR  = 6'b011110;
   localparam logic [5:0] ALU_XOR = 6'b010110;
   localparam logic [5:0] ALU_NOR = 6'b010001;
   localparam logic [5:0] ALU_STA = 6'b011010;
   localparam logic [5:0] ALU_SLL = 6'b100000;
   localparam logic [5:0] ALU_SRL = 6'b100001;
   localparam logic [5:0] ALU_SRA = 6'b100011;
   localparam logic [5:0] ALU_EQ  = 6'b110011;
   localparam logic [5:0] ALU_NEQ = 6'b110001;
   localparam logic [5:0] ALU_LT  = 6'b110101;
   localparam logic [5:0] ALU_LEZ = 6'b111101;
   localparam logic [5:0] ALU_GEZ = 6'b111001;
   localparam logic [5:0] ALU_GTZ = 6'b111111;
   localparam logic [5:0] ALU_LUI = 6'b011011;

   // B operand selects (2'd3 is reserved and never produced)
   localparam logic [1:0] BSEL_RT   = 2'd0;
   localparam logic [1:0] BSEL_IMM  = 2'd1;
   localparam logic [1:0] BSEL_ZERO = 2'd2;

   // Opcodes
   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_ADDI   = 6'h08;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_SLTI   = 6'h0A;
   localparam logic [5:0] OP_SLTIU  = 6'h0B;
   localparam logic [5:0] OP_ANDI   = 6'h0C;
   localparam logic [5:0] OP_ORI    = 6'h0D;
   localparam logic [5:0] OP_XORI   = 6'h0E;
   localparam logic [5:0] OP_LUI    = 6'h0F;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SW     = 6'h2B;

   // R-type funct codes
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_JALR = 6'h09;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   // Decoded control bundle, registered as one word in the top
   typedef struct packed {
      logic [5:0]  alu_fun;
      logic        sign;
      logic        asel;
      logic [1:0]  bsel;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  wr_reg;
      logic        reg_write;
      logic        mem_rd;
      logic        mem_wr;
      logic        branch;
      logic        illegal;
   } ctrl_bundle_t;

endpackage

// File: rtl/alu_decode_stage_if.sv
// Fetch-to-EX bus of the decode stage: instruction handshake in, control bundle out.
// slave: decode stage view (takes iInstr, drives bundle); master: the surrounding pipe.
// Flow control is valid/ready on both sides; iFlush squashes held and incoming work.
interface alu_decode_stage_if;
   import alu_pkg::*;

   logic [31:0] iInstr;
   logic        iValid;
   logic        oReady;
   logic        iFlush;
   logic        oValid;
   logic        iReady;
   logic [5:0]  oALUFun;
   logic        oSign;
   logic        oASel;
   logic [1:0]  oBSel;
   logic [31:0] oImm;
   logic [4:0]  oRs;
   logic [4:0]  oRt;
   logic [4:0]  oWrReg;
   logic        oRegWrite;
   logic        oMemRd;
   logic        oMemWr;
   logic        oBranch;
   logic        oIllegal;

   modport slave (
      input  iInstr, iValid, iFlush, iReady,
      output oReady, oValid, oALUFun, oSign, oASel, oBSel, oImm, oRs, oRt,
             oWrReg, oRegWrite, oMemRd, oMemWr, oBranch, oIllegal
   );

   modport master (
      output iInstr, iValid, iFlush, iReady,
      input  oReady, oValid, oALUFun, oSign, oASel, oBSel, oImm, oRs, oRt,
             oWrReg, oRegWrite, oMemRd, oMemWr, oBranch, oIllegal
   );

endinterface

// File: rtl/alu_ctrl_lut.sv
// Combinational MIPS decode: instruction word -> ALU control bundle.
// Latency 0 (pure lookup); no handshake, the top decides when the result is captured.
// Ports: i_instr (32b instruction), o_bundle (ctrl_bundle_t).
module alu_ctrl_lut
   import alu_pkg::*;
#(
   parameter int IMM_W = 16
) (
   input  logic [31:0]  i_instr,
   output ctrl_bundle_t o_bundle
);

   logic [5:0]   w_op;
   logic [5:0]   w_funct;
   logic [4:0]   w_rs;
   logic [4:0]   w_rt;
   logic [4:0]   w_rd;
   logic [31:0]  w_sext;
   logic [31:0]  w_zext;
   logic [31:0]  w_lui;
   logic         w_illegal;
   ctrl_bundle_t w_dec;

   assign w_op    = i_instr[31:26];
   assign w_rs    = i_instr[25:21];
   assign w_rt    = i_instr[20:16];
   assign w_rd    = i_instr[15:11];
   assign w_funct = i_instr[5:0];
   assign w_sext  = {{(32-IMM_W){i_instr[IMM_W-1]}}, i_instr[IMM_W-1:0]};
   assign w_zext  = {{(32-IMM_W){1'b0}}, i_instr[IMM_W-1:0]};
   assign w_lui   = {i_instr[15:0], 16'b0};

   always_comb begin
      w_dec           = '0;
      w_illegal       = 1'b0;
      w_dec.alu_fun   = ALU_ADD;
      w_dec.rs        = w_rs;
      w_dec.rt        = w_rt;
      w_dec.imm       = w_sext;
      // rd for R-type, rt otherwise (also for branches/stores, where it is not written)
      w_dec.wr_reg    = (w_op == OP_RTYPE) ? w_rd : w_rt;

      case (w_op)
         OP_RTYPE: begin
            w_dec.bsel      = BSEL_RT;
            w_dec.reg_write = 1'b1;
            case (w_funct)
               FN_ADD:  begin w_dec.alu_fun = ALU_ADD; w_dec.sign = 1'b1; end
               FN_ADDU: begin w_dec.alu_fun = ALU_ADD; w_dec.sign = 1'b0; end
               FN_SUB:  begin w_dec.alu_fun = ALU_SUB; w_dec.sign = 1'b1; end
               FN_SUBU: begin w_dec.alu_fun = ALU_SUB; w_dec.sign = 1'b0; end
               FN_AND:  w_dec.alu_fun = ALU_AND;
               FN_OR:   w_dec.alu_fun = ALU_OR;
               FN_XOR:  w_dec.alu_fun = ALU_XOR;
               FN_NOR:  w_dec.alu_fun = ALU_NOR;
               FN_SLT:  begin w_dec.alu_fun = ALU_LT; w_dec.sign = 1'b1; end
               FN_SLTU: begin w_dec.alu_fun = ALU_LT; w_dec.sign = 1'b0; end
               FN_SLL:  begin w_dec.alu_fun = ALU_SLL; w_dec.asel = 1'b1; end
               FN_SRL:  begin w_dec.alu_fun = ALU_SRL; w_dec.asel = 1'b1; end
               FN_SRA:  begin w_dec.alu_fun = ALU_SRA; w_dec.asel = 1'b1; end
               // jr passes rs through and writes nothing; jalr links into rd
               FN_JR:   begin w_dec.alu_fun = ALU_STA; w_dec.reg_write = 1'b0; end
               FN_JALR: w_dec.alu_fun = ALU_STA;
               default: w_illegal = 1'b1;
            endcase
         end
         OP_REGIMM: begin
            w_dec.branch = 1'b1;
            w_dec.sign   = 1'b1;
            w_dec.bsel   = BSEL_ZERO;
            case (w_rt)
               5'd0:    w_dec.alu_fun = ALU_LT;
               5'd1:    w_dec.alu_fun = ALU_GEZ;
               default: w_illegal = 1'b1;
            endcase
         end
         OP_BEQ, OP_BNE: begin
            w_dec.branch  = 1'b1;
            w_dec.sign    = 1'b1;
            w_dec.bsel    = BSEL_RT;
            w_dec.alu_fun = (w_op == OP_BEQ) ? ALU_EQ : ALU_NEQ;
         end
         OP_BLEZ, OP_BGTZ: begin
            w_dec.branch  = 1'b1;
            w_dec.sign    = 1'b1;
            w_dec.bsel    = BSEL_ZERO;
            w_dec.alu_fun = (w_op == OP_BLEZ) ? ALU_LEZ : ALU_GTZ;
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW: begin
            w_dec.bsel      = BSEL_IMM;
            w_dec.reg_write = 1'b1;
            case (w_op)
               OP_ADDI:  begin w_dec.alu_fun = ALU_ADD; w_dec.sign = 1'b1; end
               OP_ADDIU: w_dec.alu_fun = ALU_ADD;
               OP_SLTI:  begin w_dec.alu_fun = ALU_LT; w_dec.sign = 1'b1; end
               OP_SLTIU: w_dec.alu_fun = ALU_LT;
               OP_ANDI:  begin w_dec.alu_fun = ALU_AND; w_dec.imm = w_zext; end
               OP_ORI:   begin w_dec.alu_fun = ALU_OR;  w_dec.imm = w_zext; end
               OP_XORI:  begin w_dec.alu_fun = ALU_XOR; w_dec.imm = w_zext; end
               OP_LUI:   begin w_dec.alu_fun = ALU_LUI; w_dec.imm = w_lui; end
               OP_LW:    begin w_dec.alu_fun = ALU_ADD; w_dec.mem_rd = 1'b1; end
               default:  begin w_dec.alu_fun = ALU_ADD; w_dec.mem_wr = 1'b1; w_dec.reg_write = 1'b0; end
            endcase
         end
         default: w_illegal = 1'b1;
      endcase

      // Illegal instructions still travel as a valid bundle so EX can trap;
      // they must not write, access memory or branch.
      if (w_illegal) begin
         w_dec.alu_fun   = ALU_ADD;
         w_dec.sign      = 1'b0;
         w_dec.asel      = 1'b0;
         w_dec.bsel      = BSEL_RT;
         w_dec.reg_write = 1'b0;
         w_dec.mem_rd    = 1'b0;
         w_dec.mem_wr    = 1'b0;
         w_dec.branch    = 1'b0;
         w_dec.illegal   = 1'b1;
      end
   end

   assign o_bundle = w_dec;

endmodule

// File: rtl/alu_decode_stage.sv
// Decode stage register: captures one decoded instruction per accept and presents it to EX.
// Latency 1 cycle accept->oValid; oReady = !oValid || iReady, bundle holds bit-stable on stall.
// Ports: iClk, iReset (sync, active-high), bus (alu_decode_stage_if.slave).
module alu_decode_stage
   import alu_pkg::*;
#(
   parameter int IMM_W = 16
) (
   input  logic                  iClk,
   input  logic                  iReset,
   alu_decode_stage_if.slave     bus
);

   ctrl_bundle_t w_dec;
   ctrl_bundle_t r_bundle;
   logic         r_valid;
   logic         w_ready;
   logic         w_accept;

   alu_ctrl_lut #(.IMM_W(IMM_W)) u_lut (
      .i_instr  (bus.iInstr),
      .o_bundle (w_dec)
   );

   assign w_ready  = !r_valid || bus.iReady;
   assign w_accept = bus.iValid && w_ready;

   always_ff @(posedge iClk) begin
      if (iReset) begin
         r_valid  <= 1'b0;
         r_bundle <= '0;
      end else if (bus.iFlush) begin
         // An instruction accepted alongside a flush is consumed and dropped;
         // bundle data may stay stale behind oValid=0.
         r_valid <= 1'b0;
      end else if (w_ready) begin
         r_valid <= bus.iValid;
         if (w_accept) begin
            r_bundle <= w_dec;
         end
      end
   end

   assign bus.oReady    = w_ready;
   assign bus.oValid    = r_valid;
   assign bus.oALUFun   = r_bundle.alu_fun;
   assign bus.oSign     = r_bundle.sign;
   assign bus.oASel     = r_bundle.asel;
   assign bus.oBSel     = r_bundle.bsel;
   assign bus.oImm      = r_bundle.imm;
   assign bus.oRs       = r_bundle.rs;
   assign bus.oRt       = r_bundle.rt;
   assign bus.oWrReg    = r_bundle.wr_reg;
   assign bus.oRegWrite = r_bundle.reg_write;
   assign bus.oMemRd    = r_bundle.mem_rd;
   assign bus.oMemWr    = r_bundle.mem_wr;
   assign bus.oBranch   = r_bundle.branch;
   assign bus.oIllegal  = r_bundle.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: reference decoder feeds a scoreboard queue on accept,
// entries are popped and compared when EX takes a bundle, plus directed field checks.
module tb_alu_decode_stage;

   logic iClk = 1'b0;
   logic iReset;
   always #5 iClk = ~iClk;

   alu_decode_stage_if bus ();

   alu_decode_stage #(.IMM_W(16)) dut (
      .iClk   (iClk),
      .iReset (iReset),
      .bus    (bus)
   );

   int           n_tests = 0;
   int           n_fail  = 0;
   int           n_popped = 0;
   logic [61:0]  sb_q[$];

   task automatic tb_check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [61:0] obs_vec();
      return {bus.oALUFun, bus.oSign, bus.oASel, bus.oBSel, bus.oImm, bus.oRs, bus.oRt,
              bus.oWrReg, bus.oRegWrite, bus.oMemRd, bus.oMemWr, bus.oBranch, bus.oIllegal};
   endfunction

   // Reference decoder written from the instruction tables
   function automatic logic [61:0] ref_decode(input logic [31:0] ins);
      logic [5:0]  op, fn, alu;
      logic        sg, as, rw, mr, mw, br, il;
      logic [1:0]  bs;
      logic [31:0] im;
      logic [4:0]  wr;
      op = ins[31:26];
      fn = ins[5:0];
      alu = 6'b000000; sg = 0; as = 0; bs = 2'd0; rw = 0; mr = 0; mw = 0; br = 0; il = 0;
      im = {{16{ins[15]}}, ins[15:0]};
      wr = (op == 6'h00) ? ins[15:11] : ins[20:16];
      if (op == 6'h00) begin
         rw = 1;
         case (fn)
            6'h20: begin alu = 6'b000000; sg = 1; end
            6'h21: alu = 6'b000000;
            6'h22: begin alu = 6'b000001; sg = 1; end
            6'h23: alu = 6'b000001;
            6'h24: alu = 6'b011000;
            6'h25: alu = 6'b011110;
            6'h26: alu = 6'b010110;
            6'h27: alu = 6'b010001;
            6'h2A: begin alu = 6'b110101; sg = 1; end
            6'h2B: alu = 6'b110101;
            6'h00: begin alu = 6'b100000; as = 1; end
            6'h02: begin alu = 6'b100001; as = 1; end
            6'h03: begin alu = 6'b100011; as = 1; end
            6'h08: begin alu = 6'b011010; rw = 0; end
            6'h09: alu = 6'b011010;
            default: il = 1;
         endcase
      end else if (op == 6'h01) begin
         br = 1; sg = 1; bs = 2'd2;
         if (ins[20:16] == 5'd0) alu = 6'b110101;
         else if (ins[20:16] == 5'd1) alu = 6'b111001;
         else il = 1;
      end else if (op >= 6'h04 && op <= 6'h07) begin
         br = 1; sg = 1;
         bs  = (op >= 6'h06) ? 2'd2 : 2'd0;
         alu = (op == 6'h04) ? 6'b110011 : (op == 6'h05) ? 6'b110001 :
               (op == 6'h06) ? 6'b111101 : 6'b111111;
      end else if ((op >= 6'h08 && op <= 6'h0F) || op == 6'h23 || op == 6'h2B) begin
         bs = 2'd1; rw = 1;
         case (op)
            6'h08: begin alu = 6'b000000; sg = 1; end
            6'h0A: begin alu = 6'b110101; sg = 1; end
            6'h0B: alu = 6'b110101;
            6'h0C: begin alu = 6'b011000; im = {16'h0, ins[15:0]}; end
            6'h0D: begin alu = 6'b011110; im = {16'h0, ins[15:0]}; end
            6'h0E: begin alu = 6'b010110; im = {16'h0, ins[15:0]}; end
            6'h0F: begin alu = 6'b011011; im = {ins[15:0], 16'h0}; end
            6'h23: mr = 1;
            6'h2B: begin mw = 1; rw = 0; end
            default: alu = 6'b000000;
         endcase
      end else begin
         il = 1;
      end
      if (il) begin
         alu = 6'b000000; sg = 0; as = 0; bs = 2'd0; rw = 0; mr = 0; mw = 0; br = 0;
      end
      return {alu, sg, as, bs, im, ins[25:21], ins[20:16], wr, rw, mr, mw, br, il};
   endfunction

   // One clock: settle, score the EX handshake and the fetch accept, then advance to the next negedge.
   task automatic cycle();
      logic [61:0] e;
      #1;
      if (iReset) begin
         sb_q.delete();
      end else begin
         if (bus.oValid && (bus.iReady || bus.iFlush)) begin
            tb_check("sb_has_entry", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               if (bus.iReady) begin
                  tb_check("bundle", 64'(obs_vec()), 64'(e));
                  n_popped++;
               end
            end
         end
         if (bus.iValid && bus.oReady && !bus.iFlush)
            sb_q.push_back(ref_decode(bus.iInstr));
      end
      @(posedge iClk);
      @(negedge iClk);
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
      bus.iValid = v;
      bus.iInstr = ins;
      bus.iReady = rdy;
      bus.iFlush = fl;
   endtask

   logic [31:0] stream_tbl [16] = '{
      32'h012A4020, 32'h04020000, 32'h012A4022, 32'h012A4024,
      32'h012A4025, 32'h012A4026, 32'h012A4027, 32'h012A402A,
      32'h012A402B, 32'h000A4100, 32'h000A4103, 32'h01200008,
      32'h8D28FFF0, 32'hAD280004, 32'h11090010, 32'h04010000
   };

   initial begin
      logic [61:0] snap;
      int          base;
      iReset = 1'b1;
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      @(negedge iClk);
      cycle();
      cycle();
      tb_check("rst_valid", 64'(bus.oValid), 64'd0);
      tb_check("rst_bundle", 64'(obs_vec()), 64'd0);

      // Reset arriving right after an accept wipes the bundle
      iReset = 1'b0;
      drive(1'b1, 32'h012A4020, 1'b1, 1'b0);
      cycle();
      tb_check("pre_rst_valid", 64'(bus.oValid), 64'd1);
      iReset = 1'b1;
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      cycle();
      tb_check("midrst_valid", 64'(bus.oValid), 64'd0);
      tb_check("midrst_alufun", 64'(bus.oALUFun), 64'd0);
      tb_check("midrst_bundle", 64'(obs_vec()), 64'd0);
      iReset = 1'b0;

      // add then lui
      drive(1'b1, 32'h012A4020, 1'b1, 1'b0);
      cycle();
      tb_check("add_valid", 64'(bus.oValid), 64'd1);
      tb_check("add_alufun", 64'(bus.oALUFun), 64'b000000);
      tb_check("add_sign", 64'(bus.oSign), 64'd1);
      tb_check("add_bsel", 64'(bus.oBSel), 64'd0);
      tb_check("add_wrreg", 64'(bus.oWrReg), 64'd8);
      tb_check("add_regwr", 64'(bus.oRegWrite), 64'd1);
      drive(1'b1, 32'h3C08ABCD, 1'b1, 1'b0);
      cycle();
      tb_check("lui_alufun", 64'(bus.oALUFun), 64'b011011);
      tb_check("lui_imm", 64'(bus.oImm), 64'hABCD0000);

      // Stall three cycles with a new instruction offered
      drive(1'b1, 32'h3108FFFF, 1'b0, 1'b0);
      snap = obs_vec();
      for (int i = 0; i < 3; i++) begin
         #1 tb_check("stall_ready", 64'(bus.oReady), 64'd0);
         cycle();
         tb_check("stall_valid", 64'(bus.oValid), 64'd1);
         tb_check("stall_hold", 64'(obs_vec()), 64'(snap));
      end
      bus.iReady = 1'b1;
      cycle();
      tb_check("andi_valid", 64'(bus.oValid), 64'd1);
      tb_check("andi_imm", 64'(bus.oImm), 64'h0000FFFF);

      // Flush while stalled with an instruction offered
      drive(1'b1, 32'h2108FFFF, 1'b0, 1'b1);
      #1 tb_check("flush_ready", 64'(bus.oReady), 64'd0);
      cycle();
      tb_check("flush_valid", 64'(bus.oValid), 64'd0);
      drive(1'b1, 32'h2108FFFF, 1'b1, 1'b0);
      cycle();
      tb_check("addi_valid", 64'(bus.oValid), 64'd1);
      tb_check("addi_imm", 64'(bus.oImm), 64'hFFFFFFFF);

      // bltz
      drive(1'b1, 32'h04000000, 1'b1, 1'b0);
      cycle();
      tb_check("bltz_alufun", 64'(bus.oALUFun), 64'b110101);
      tb_check("bltz_bsel", 64'(bus.oBSel), 64'd2);
      tb_check("bltz_branch", 64'(bus.oBranch), 64'd1);

      // Illegal opcode 0x3F
      drive(1'b1, 32'hFC000000, 1'b1, 1'b0);
      cycle();
      tb_check("ill_valid", 64'(bus.oValid), 64'd1);
      tb_check("ill_flag", 64'(bus.oIllegal), 64'd1);
      tb_check("ill_regwr", 64'(bus.oRegWrite), 64'd0);

      // Bubble: nothing offered while EX drains
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      cycle();
      tb_check("bubble_valid", 64'(bus.oValid), 64'd0);

      // Back-to-back stream
      base = n_popped;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, stream_tbl[i], 1'b1, 1'b0);
         cycle();
         tb_check("stream_valid", 64'(bus.oValid), 64'd1);
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      for (int k = 0; k < 8 && sb_q.size() > 0; k++) cycle();
      tb_check("drain_empty", 64'(sb_q.size()), 64'd0);
      tb_check("stream_count", 64'(n_popped - base), 64'd16);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
      $fatal(1, "watchdog");
   end

endmodule
